// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the control vector and its canned values.
// Optional perf counters in the top are enabled with HAZARD_PERF_CNT_EN.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_hold;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                   id_ex_flush: 1'b0, pipe_hold: 1'b0, mem_wb_bubble: 1'b0};

    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b0, pipe_hold: 1'b1, mem_wb_bubble: 1'b1};

    localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                     id_ex_flush: 1'b1, pipe_hold: 1'b0, mem_wb_bubble: 1'b0};

    // Dead pipeline after a memory timeout: nothing loads, everything holds.
    localparam ctrl_t CTRL_HALT = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_flush: 1'b0, pipe_hold: 1'b1, mem_wb_bubble: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources of the ID instruction.
// Kept standalone so the forwarding unit can reuse the same compare.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze, load-use stall, branch/jump flush, wait watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pipe_hold,
    output logic        mem_wb_bubble,
    output logic        mem_timeout,
    output logic [1:0]  state,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q;
    logic             load_use;
    ctrl_t            run_ctrl;
    ctrl_t            ctrl;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hazard      (load_use)
    );

    // RUN priorities below the memory freeze; also used on the MEM_WAIT release cycle.
    always_comb begin
        run_ctrl = CTRL_RUN;
        if (ex_branch_taken) begin
            run_ctrl.if_id_flush = 1'b1;
            run_ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            // Any jump in ID stays put in IF/ID and resolves on the following cycle.
            run_ctrl.pc_write    = 1'b0;
            run_ctrl.if_id_write = 1'b0;
            run_ctrl.id_ex_flush = 1'b1;
        end else if (id_jump) begin
            run_ctrl.if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = CTRL_RUN;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end else begin
                    ctrl = run_ctrl;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl       = run_ctrl;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_d = TIMEOUT;
                    end else if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end
                end
            end
            TIMEOUT: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                ctrl       = CTRL_FREEZE;
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (reset) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_q | (state_d == TIMEOUT);
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign pipe_hold     = ctrl.pipe_hold;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign mem_timeout   = timeout_q;
    assign state         = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctrl.pc_write) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ctrl.if_id_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (WAIT_TIMEOUT=4); control vector order is
// {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_bubble}.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_jump;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        pipe_hold;
    logic        mem_wb_bubble;
    logic        mem_timeout;
    logic [1:0]  state;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    logic [5:0]  ctrl_obs;

    int n_cmp;
    int n_fail;

    localparam logic [5:0] V_RUN    = 6'b110000;
    localparam logic [5:0] V_LU     = 6'b000100;
    localparam logic [5:0] V_BR     = 6'b111100;
    localparam logic [5:0] V_JMP    = 6'b111000;
    localparam logic [5:0] V_FREEZE = 6'b000011;
    localparam logic [5:0] V_RESET  = 6'b001100;
    localparam logic [5:0] V_HALT   = 6'b000010;

    pipeline_hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .pipe_hold       (pipe_hold),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_timeout     (mem_timeout),
        .state           (state),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
    );

    assign ctrl_obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_bubble};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_obs !== V_RESET) begin
                n_fail++; $display("FAIL reset_ctrl[%0d]: got %b expected %b", i, ctrl_obs, V_RESET);
            end
            cyc();
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL first_run_ctrl: got %b expected %b", ctrl_obs, V_RUN);
        end
        n_cmp++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL first_run_state: got %0d expected 0", state);
        end
        n_cmp++;
        if (mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL first_run_timeout: got %b expected 0", mem_timeout);
        end
        cyc();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_LU) begin
            n_fail++; $display("FAIL lu_rs_stall: got %b expected %b", ctrl_obs, V_LU);
        end
        cyc();
        ex_mem_read = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL lu_one_cycle: got %b expected %b", ctrl_obs, V_RUN);
        end
        cyc();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL lu_r0_no_stall: got %b expected %b", ctrl_obs, V_RUN);
        end
        cyc();
        ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL lu_rt_unused: got %b expected %b", ctrl_obs, V_RUN);
        end
        cyc();
        id_uses_rt = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_LU) begin
            n_fail++; $display("FAIL lu_rt_used: got %b expected %b", ctrl_obs, V_LU);
        end
        cyc();
        idle();
    endtask

    task automatic test_branch_jump();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_jump = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_BR) begin
            n_fail++; $display("FAIL branch_priority: got %b expected %b", ctrl_obs, V_BR);
        end
        cyc();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_LU) begin
            n_fail++; $display("FAIL jump_deferred: got %b expected %b", ctrl_obs, V_LU);
        end
        cyc();
        ex_mem_read = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_JMP) begin
            n_fail++; $display("FAIL jump_flush: got %b expected %b", ctrl_obs, V_JMP);
        end
        cyc();
        idle();
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl_obs !== V_FREEZE) begin
                n_fail++; $display("FAIL wait_freeze[%0d]: got %b expected %b", i, ctrl_obs, V_FREEZE);
            end
            n_cmp++;
            if (state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                n_fail++; $display("FAIL wait_state[%0d]: got %0d expected %0d", i, state, (i == 0) ? 0 : 1);
            end
            cyc();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_BR) begin
            n_fail++; $display("FAIL wait_release_flush: got %b expected %b", ctrl_obs, V_BR);
        end
        cyc();
        idle();
        @(negedge clk);
        n_cmp++;
        if (state !== 2'd0 || ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL wait_back_to_run: got state %0d ctrl %b expected 0 %b", state, ctrl_obs, V_RUN);
        end
        cyc();
        mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'd0 || ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL ready_without_req: got state %0d ctrl %b expected 0 %b", state, ctrl_obs, V_RUN);
        end
        cyc();
        mem_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL req_ready_same_cycle: got %b expected %b", ctrl_obs, V_RUN);
        end
        cyc();
        idle();
    endtask

    task automatic test_timeout();
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (state !== 2'd1 || mem_timeout !== 1'b0 || ctrl_obs !== V_FREEZE) begin
                n_fail++; $display("FAIL wait_cycle[%0d]: got state %0d timeout %b ctrl %b expected 1 0 %b",
                                   i, state, mem_timeout, ctrl_obs, V_FREEZE);
            end
            cyc();
        end
        @(negedge clk);
        n_cmp++;
        if (state !== 2'd2 || mem_timeout !== 1'b1 || ctrl_obs !== V_HALT) begin
            n_fail++; $display("FAIL timeout_entry: got state %0d timeout %b ctrl %b expected 2 1 %b",
                               state, mem_timeout, ctrl_obs, V_HALT);
        end
        cyc();
        mem_ready = 1'b1;
        cyc();
        @(negedge clk);
        n_cmp++;
        if (state !== 2'd2 || mem_timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: got state %0d timeout %b expected 2 1", state, mem_timeout);
        end
        cyc();
        idle();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl_obs !== V_RESET) begin
            n_fail++; $display("FAIL timeout_reset_ctrl: got %b expected %b", ctrl_obs, V_RESET);
        end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'd0 || mem_timeout !== 1'b0 || ctrl_obs !== V_RUN) begin
            n_fail++; $display("FAIL timeout_cleared: got state %0d timeout %b ctrl %b expected 0 0 %b",
                               state, mem_timeout, ctrl_obs, V_RUN);
        end
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        n_cmp++;
        if (state !== 2'd1) begin
            n_fail++; $display("FAIL mid_wait_state: got %0d expected 1", state);
        end
        cyc();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'd0 || ctrl_obs !== V_RUN || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait_abort: got state %0d ctrl %b timeout %b expected 0 %b 0",
                               state, ctrl_obs, mem_timeout, V_RUN);
        end
        cyc();
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 32'd1;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc();
        idle();
        ex_branch_taken = 1'b1;
        cyc();
        idle();
        id_jump = 1'b1;
        cyc();
        idle();
        @(negedge clk);
        n_cmp++;
        if (perf_stall_cnt !== exp_stall) begin
            n_fail++; $display("FAIL perf_stall_cnt: got %0d expected %0d", perf_stall_cnt, exp_stall);
        end
        n_cmp++;
        if (perf_flush_cnt !== exp_flush) begin
            n_fail++; $display("FAIL perf_flush_cnt: got %0d expected %0d", perf_flush_cnt, exp_flush);
        end
        cyc();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_load_use();
        test_branch_jump();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle whether PC and IF/ID load, hold or flush, and whether ID/EX is bubbled.
- Freezes the whole pipeline while the data memory in MEM stage is not ready.
- Detects load-use hazards and resolves branch/jump redirects; a wait-timeout watchdog latches a fatal error.

Parameters:
- WAIT_TIMEOUT, 255: max consecutive MEM_WAIT cycles before entering TIMEOUT; legal range 1..65535.
- CNT_W, 16: width of the wait counter; must hold WAIT_TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_jump  in  1  jump/jal/jr decoded in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of that load
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM-stage access in progress
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_flush  out  1  ID/EX control clear (RegWrite/MemWrite = 0)
- pipe_hold  out  1  hold ID/EX, EX/MEM
- mem_wb_bubble  out  1  insert bubble into MEM/WB
- mem_timeout  out  1  sticky fatal error
- state  out  2  current FSM state, for debug
- perf_stall_cnt  out  32  stall-cycle count (optional feature)
- perf_flush_cnt  out  32  flush-event count (optional feature)

Interface rule: one clock (clk); reset is synchronous and active-high.

Behaviour:
- States (2 bits): RUN=0, MEM_WAIT=1, TIMEOUT=2. Encoding 3 is illegal and goes to RUN.
- Reset: synchronous and active-high; sets state=RUN, wait_cnt=0, mem_timeout=0.
  - While reset is high, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0, mem_wb_bubble=0.
  - Reset asserted mid-wait aborts the wait with no residue.
- Outputs are combinational from state plus current inputs, so latency is 0 cycles.
- Default in RUN: pc_write=1, if_id_write=1, all flush/hold/bubble outputs 0.
- Priority in RUN, highest first:
  1. mem_req && !mem_ready: freeze (pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_bubble=1). Next state MEM_WAIT, wait_cnt=1.
  2. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. Load-use and jump are ignored because the instructions are squashed.
  3. Load-use: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)). Drives pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle. A simultaneous id_jump is deferred; the jump resolves next cycle.
  4. id_jump: if_id_flush=1.
- MEM_WAIT:
  - Freeze outputs as in priority 1; wait_cnt increments each cycle.
  - On mem_ready=1: go to RUN and, in the same cycle, evaluate the RUN priorities 2–4. ex_branch_taken remains valid because EX is held, so it is never lost.
  - If wait_cnt==WAIT_TIMEOUT && !mem_ready: go to TIMEOUT.
- TIMEOUT: mem_timeout=1, all enables 0, pipe_hold=1. Only reset exits.
- mem_ready=1 while mem_req=0 is ignored.
- wait_cnt saturates and never wraps.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - perf_stall_cnt increments on every cycle with pc_write=0 outside reset.
  - perf_flush_cnt increments on every cycle with if_id_flush=1 outside reset.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- When undefined: both ports are present and tied to 0; no counter flops are synthesized.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state enum/localparams RUN/MEM_WAIT/TIMEOUT;
  - REG_ZERO=5'd0;
  - control-vector struct {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_bubble};
  - CTRL_RUN, CTRL_FREEZE and CTRL_RESET constants.
- One sub-module: load_use_detect (purely combinational hazard compare), reusable by the forwarding unit.

Test Plan:
- Reset for 2 cycles then release, no requests -> reset cycles show if_id_flush=1, pc_write=0; first RUN cycle shows pc_write=1, state=0.
- ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. With ex_rt=0 -> no stall. With id_rt=8 and id_uses_rt=0 -> no stall.
- ex_branch_taken=1 together with a load-use hit and id_jump=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1.
- mem_req=1, mem_ready=0 for 3 cycles then 1, with ex_branch_taken=1 held -> freeze 3 cycles (state=1), release cycle flushes both registers, state=0.
- WAIT_TIMEOUT=4, mem_ready held 0 -> state=2 and mem_timeout=1 after 4 wait cycles and held; reset clears both.
- With HAZARD_PERF_CNT_EN: 1 load-use stall, 1 branch, 1 jump -> perf_stall_cnt=1, perf_flush_cnt=2.
